// File: rtl/x86_insn_scanner_if.sv
// x86_insn_scanner_if: byte input stream and per-instruction record output of the scanner.
// slave is the scanner side, master is the producer/consumer side.
interface x86_insn_scanner_if;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_len;
    logic [7:0] out_opcode;
    logic       out_esc;
    logic [3:0] out_rex;
    logic [3:0] out_pfx;
    logic [7:0] out_modrm;
    logic       out_has_modrm;
    logic       out_err;
    modport slave (
        input  in_valid, in_byte, out_ready,
        output in_ready, out_valid, out_len, out_opcode, out_esc, out_rex, out_pfx,
               out_modrm, out_has_modrm, out_err
    );
    modport master (
        output in_valid, in_byte, out_ready,
        input  in_ready, out_valid, out_len, out_opcode, out_esc, out_rex, out_pfx,
               out_modrm, out_has_modrm, out_err
    );
endinterface

// File: rtl/x86_insn_scanner.sv
// x86_insn_scanner: byte-serial x86-64 instruction boundary scanner emitting one record per instruction.
// Define INSN_LEN_LIMIT_EN to cut instructions at MAX_LEN bytes and flag them with out_err.
module x86_insn_scanner #(
    parameter int MAX_LEN = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic [255:0]         modrm_map,
    x86_insn_scanner_if.slave    bus
);
    typedef enum logic [2:0] {PFX, ESC, MODRM, SIB, DISP, IMM, EMIT} state_t;

    state_t     state, state_n;
    logic [3:0] len, len_n, rex, rex_n, pfx, pfx_n, icnt, icnt_n, pb, z;
    logic [7:0] op, op_n, modrm, modrm_n, b;
    logic [2:0] dcnt, dcnt_n, dsp;
    logic       esc, esc_n, has, has_n, err, err_n, clr;

    function automatic logic [3:0] imm_size(input logic [7:0] o, input logic w, input logic [3:0] zs);
        return (o < 8'h40 && o[2:0] == 3'd4) ? 4'd1 :
               (o < 8'h40 && o[2:0] == 3'd5) ? zs :
               (o inside {8'h6A, 8'h6B, [8'h70:8'h7F], 8'h80, 8'h83, 8'hA8, [8'hB0:8'hB7],
                          8'hC0, 8'hC1, 8'hC6, 8'hCD, [8'hE0:8'hE7], 8'hEB}) ? 4'd1 :
               (o inside {8'h68, 8'h69, 8'h81, 8'hA9, 8'hC7}) ? zs :
               (o inside {8'hE8, 8'hE9}) ? 4'd4 :
               (o[7:3] == 5'h17) ? (w ? 4'd8 : zs) :
               (o == 8'hC2) ? 4'd2 :
               (o == 8'hC8) ? 4'd3 : 4'd0;
    endfunction

    assign bus.in_ready      = (state != EMIT) || bus.out_ready;
    assign bus.out_valid     = (state == EMIT);
    assign bus.out_len       = len;
    assign bus.out_opcode    = op;
    assign bus.out_esc       = esc;
    assign bus.out_rex       = rex;
    assign bus.out_pfx       = pfx;
    assign bus.out_modrm     = modrm;
    assign bus.out_has_modrm = has;
    assign bus.out_err       = err;

    always_comb begin
        // A released record clears per-insn state so a byte in the same cycle starts afresh
        clr     = (state == EMIT) && bus.out_ready;
        state_n = clr ? PFX : state;
        len_n   = clr ? '0 : len;
        op_n    = clr ? '0 : op;
        esc_n   = clr ? 1'b0 : esc;
        rex_n   = clr ? '0 : rex;
        pfx_n   = clr ? '0 : pfx;
        modrm_n = clr ? '0 : modrm;
        has_n   = clr ? 1'b0 : has;
        dcnt_n  = clr ? '0 : dcnt;
        icnt_n  = clr ? '0 : icnt;
        err_n   = clr ? 1'b0 : err;
        b       = bus.in_byte;
        z       = pfx_n[3] ? 4'd2 : 4'd4;
        pb      = (b == 8'h66) ? 4'b1000 :
                  (b == 8'h67) ? 4'b0100 :
                  (b == 8'hF2 || b == 8'hF3) ? 4'b0010 :
                  (b inside {8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65, 8'hF0}) ? 4'b0001 : 4'b0000;
        dsp     = (b[7:6] == 2'b01) ? 3'd1 :
                  (b[7:6] == 2'b10 || (b[7:6] == 2'b00 && b[2:0] == 3'd5)) ? 3'd4 : 3'd0;
        if (bus.in_valid && bus.in_ready) begin
            len_n = (len_n == 4'(MAX_LEN)) ? len_n : len_n + 4'd1;
            case (state_n)
                PFX: begin
                    if (pb != 4'd0) begin
                        pfx_n = pfx_n | pb;
                        rex_n = '0;
                    end else if (b[7:4] == 4'h4) begin
                        rex_n = b[3:0];
                    end else if (b == 8'h0F) begin
                        esc_n   = 1'b1;
                        state_n = ESC;
                    end else begin
                        op_n    = b;
                        icnt_n  = imm_size(b, rex_n[3], z);
                        state_n = modrm_map[b] ? MODRM : (icnt_n != 4'd0) ? IMM : EMIT;
                    end
                end
                ESC: begin
                    op_n    = b;
                    state_n = MODRM;
                end
                MODRM: begin
                    modrm_n = b;
                    has_n   = 1'b1;
                    dcnt_n  = dsp;
                    if (!esc_n && op_n[7:1] == 7'h7B)
                        icnt_n = (b[5:3] == 3'd0) ? (op_n[0] ? z : 4'd1) : 4'd0;
                    state_n = (b[2:0] == 3'd4 && b[7:6] != 2'b11) ? SIB :
                              (dcnt_n != 3'd0) ? DISP : (icnt_n != 4'd0) ? IMM : EMIT;
                end
                SIB: begin
                    if (modrm_n[7:6] == 2'b00 && b[2:0] == 3'd5)
                        dcnt_n = 3'd4;
                    state_n = (dcnt_n != 3'd0) ? DISP : (icnt_n != 4'd0) ? IMM : EMIT;
                end
                DISP: begin
                    dcnt_n  = dcnt_n - 3'd1;
                    state_n = (dcnt_n != 3'd0) ? DISP : (icnt_n != 4'd0) ? IMM : EMIT;
                end
                IMM: begin
                    icnt_n  = icnt_n - 4'd1;
                    state_n = (icnt_n != 4'd0) ? IMM : EMIT;
                end
                default: ;
            endcase
`ifdef INSN_LEN_LIMIT_EN
            if (state_n != EMIT && len_n == 4'(MAX_LEN)) begin
                state_n = EMIT;
                err_n   = 1'b1;
            end
`endif
        end
        if (flush) begin
            state_n = PFX;
            len_n   = '0;
            op_n    = '0;
            esc_n   = 1'b0;
            rex_n   = '0;
            pfx_n   = '0;
            modrm_n = '0;
            has_n   = 1'b0;
            dcnt_n  = '0;
            icnt_n  = '0;
            err_n   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= PFX;
            len   <= '0;
            op    <= '0;
            esc   <= 1'b0;
            rex   <= '0;
            pfx   <= '0;
            modrm <= '0;
            has   <= 1'b0;
            dcnt  <= '0;
            icnt  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            len   <= len_n;
            op    <= op_n;
            esc   <= esc_n;
            rex   <= rex_n;
            pfx   <= pfx_n;
            modrm <= modrm_n;
            has   <= has_n;
            dcnt  <= dcnt_n;
            icnt  <= icnt_n;
            err   <= err_n;
        end
    end
endmodule
